// File: rtl/saph_fpu_issue.sv
// saph_fpu_issue: credit-based issue queue in front of a pipelined FPU.
// Request FIFO -> FPU, tag shift register, result FIFO -> requester.
module saph_fpu_issue #(
  parameter int DEPTH   = 4,
  parameter int RDEPTH  = 4,
  parameter int LATENCY = 2,
  parameter int MODE_W  = 4,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_lhs,
  input  logic [31:0]       req_rhs,
  input  logic [MODE_W-1:0] req_mode,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              fpu_trig,
  output logic [31:0]       fpu_lhs,
  output logic [31:0]       fpu_rhs,
  output logic [MODE_W-1:0] fpu_mode,
  input  logic              fpu_res_valid,
  input  logic [31:0]       fpu_res,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              err
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int RPW = $clog2(RDEPTH);
  localparam int RCW = RPW + 1;
  localparam int UW  = RCW + 1;
  localparam int QW  = 64 + MODE_W + TAG_W;
  localparam int RW  = 32 + TAG_W;

  logic [QW-1:0]      rq_mem_q [DEPTH];
  logic [PW-1:0]      rq_wp_q, rq_wp_d;
  logic [PW-1:0]      rq_rp_q, rq_rp_d;
  logic [CW-1:0]      rq_cnt_q, rq_cnt_d;

  logic [RW-1:0]      rs_mem_q [RDEPTH];
  logic [RPW-1:0]     rs_wp_q, rs_wp_d;
  logic [RPW-1:0]     rs_rp_q, rs_rp_d;
  logic [RCW-1:0]     rs_cnt_q, rs_cnt_d;

  logic [RCW-1:0]     infl_q, infl_d;
  logic [LATENCY-1:0] tv_q, tv_d;
  logic [TAG_W-1:0]   tt_q [LATENCY];
  logic               err_q, err_d;

  logic [UW-1:0]      used;
  logic [QW-1:0]      head;
  logic               push, issue, wr, pop, tv_out;

  assign head      = rq_mem_q[rq_rp_q];
  assign req_ready = rq_cnt_q < CW'(DEPTH);
  assign push      = req_valid && req_ready;
  // Outstanding = in flight + parked in the result FIFO.
  assign used      = UW'(infl_q) + UW'(rs_cnt_q);
  assign issue     = rst && (rq_cnt_q != '0)
                     && (used < UW'(RDEPTH));
  assign tv_out    = tv_q[LATENCY-1];
  assign wr        = tv_out && fpu_res_valid;
  assign res_valid = rst && (rs_cnt_q != '0);
  assign pop       = res_valid && res_ready;
  assign err       = err_q;

  assign fpu_trig  = issue;
  assign {fpu_lhs, fpu_rhs, fpu_mode} =
    issue ? head[QW-1:TAG_W] : '0;
  assign {res_data, res_tag} =
    res_valid ? rs_mem_q[rs_rp_q] : '0;

  // Next-state for pointers, counts, tag valids and the error flag.
  always_comb begin
    rq_wp_d  = rq_wp_q + PW'(push);
    rq_rp_d  = rq_rp_q + PW'(issue);
    rq_cnt_d = rq_cnt_q + CW'(push) - CW'(issue);
    rs_wp_d  = rs_wp_q + RPW'(wr);
    rs_rp_d  = rs_rp_q + RPW'(pop);
    rs_cnt_d = rs_cnt_q + RCW'(wr) - RCW'(pop);
    infl_d   = infl_q + RCW'(issue) - RCW'(tv_out);
    tv_d     = (tv_q << 1) | LATENCY'(issue);
    err_d    = err_q | (fpu_res_valid != tv_out);
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rq_wp_q  <= '0;
      rq_rp_q  <= '0;
      rq_cnt_q <= '0;
      rs_wp_q  <= '0;
      rs_rp_q  <= '0;
      rs_cnt_q <= '0;
      infl_q   <= '0;
      tv_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      rq_wp_q  <= rq_wp_d;
      rq_rp_q  <= rq_rp_d;
      rq_cnt_q <= rq_cnt_d;
      rs_wp_q  <= rs_wp_d;
      rs_rp_q  <= rs_rp_d;
      rs_cnt_q <= rs_cnt_d;
      infl_q   <= infl_d;
      tv_q     <= tv_d;
      err_q    <= err_d;
    end
  end

  // Storage: FIFO payloads and the tag pipe need no reset.
  always_ff @(posedge clk) begin
    if (push)
      rq_mem_q[rq_wp_q] <= {req_lhs, req_rhs, req_mode, req_tag};
    if (wr)
      rs_mem_q[rs_wp_q] <= {fpu_res, tt_q[LATENCY-1]};
    tt_q[0] <= head[TAG_W-1:0];
    for (int i = 1; i < LATENCY; i++)
      tt_q[i] <= tt_q[i-1];
  end

endmodule

// File: tb/tb_saph_fpu_issue.sv
// tb_saph_fpu_issue: directed tests with a fixed-latency FPU model.
// Expected values are hand-computed binary32 constants.
module tb_saph_fpu_issue;
  localparam int MW = 4;
  localparam int TW = 4;
  localparam logic [MW-1:0] ADD = 4'd0;
  localparam logic [MW-1:0] MUL = 4'd2;
  localparam logic [MW-1:0] DIV = 4'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [31:0] req_lhs = '0;
  logic [31:0] req_rhs = '0;
  logic [MW-1:0] req_mode = '0;
  logic [TW-1:0] req_tag = '0;
  logic fpu_trig;
  logic [31:0] fpu_lhs, fpu_rhs;
  logic [MW-1:0] fpu_mode;
  logic fpu_res_valid;
  logic [31:0] fpu_res;
  logic res_valid;
  logic res_ready = 1'b1;
  logic [31:0] res_data;
  logic [TW-1:0] res_tag;
  logic err;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  saph_fpu_issue dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_lhs(req_lhs), .req_rhs(req_rhs),
    .req_mode(req_mode), .req_tag(req_tag),
    .fpu_trig(fpu_trig), .fpu_lhs(fpu_lhs),
    .fpu_rhs(fpu_rhs), .fpu_mode(fpu_mode),
    .fpu_res_valid(fpu_res_valid), .fpu_res(fpu_res),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag),
    .err(err)
  );

  function automatic logic [31:0] fmodel(
    input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'hBF800000_40A00000: fmodel = 32'h40800000;
      64'hC0600000_40800000: fmodel = 32'hC1600000;
      64'h411B3333_3F000000: fmodel = 32'h409B3333;
      64'h43400000_42800000: fmodel = 32'h40400000;
      default:               fmodel = a ^ b;
    endcase
  endfunction

  logic [1:0] pv = '0;
  logic [31:0] pd0 = '0;
  logic [31:0] pd1 = '0;
  logic inj = 1'b0;

  always @(posedge clk) begin
    pv  <= {pv[0], fpu_trig};
    pd0 <= fmodel(fpu_lhs, fpu_rhs);
    pd1 <= pd0;
  end

  assign fpu_res_valid = pv[1] | inj;
  assign fpu_res = pd1;

  logic [35:0] got_q [$];
  always @(negedge clk)
    if (res_valid && res_ready)
      got_q.push_back({res_tag, res_data});

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v,
                         input logic [31:0] l,
                         input logic [31:0] r,
                         input logic [MW-1:0] m,
                         input logic [TW-1:0] t);
    req_valid = v;
    req_lhs = l;
    req_rhs = r;
    req_mode = m;
    req_tag = t;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0);
    tick;
    tick;
    @(negedge clk);
    n_tests++;
    if ({req_ready, fpu_trig, fpu_lhs, fpu_rhs,
         fpu_mode, res_valid, err}
        !== {1'b1, 1'b0, 68'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset rdy=%b trig=%b lhs=%h rv=%b err=%b want 1 0 0 0 0",
               req_ready, fpu_trig, fpu_lhs, res_valid, err);
    end
    tick;
    rst = 1'b1;
  endtask

  task automatic test_single;
    set_req(1, 32'hBF800000, 32'h40A00000, ADD, 4'd3);
    @(negedge clk);
    n_tests++;
    if ({req_ready, fpu_trig} !== 2'b10) begin
      n_fail++;
      $display("FAIL single_c1 rdy,trig=%b want 10",
               {req_ready, fpu_trig});
    end
    tick;
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if ({fpu_trig, fpu_lhs, fpu_rhs, fpu_mode}
        !== {1'b1, 32'hBF800000, 32'h40A00000, ADD}) begin
      n_fail++;
      $display("FAIL single_c2 trig=%b lhs=%h rhs=%h mode=%h",
               fpu_trig, fpu_lhs, fpu_rhs, fpu_mode);
    end
    tick;
    @(negedge clk);
    n_tests++;
    if ({fpu_trig, fpu_lhs, fpu_rhs, fpu_mode} !== '0) begin
      n_fail++;
      $display("FAIL single_c3 trig=%b lhs=%h want 0 0",
               fpu_trig, fpu_lhs);
    end
    tick;
    @(negedge clk);
    n_tests++;
    if ({fpu_res_valid, fpu_res, res_valid}
        !== {1'b1, 32'h40800000, 1'b0}) begin
      n_fail++;
      $display("FAIL single_c4 frv=%b res=%h rv=%b want 1 40800000 0",
               fpu_res_valid, fpu_res, res_valid);
    end
    tick;
    @(negedge clk);
    n_tests++;
    if ({res_valid, res_data, res_tag}
        !== {1'b1, 32'h40800000, 4'd3}) begin
      n_fail++;
      $display("FAIL single_c5 rv=%b data=%h tag=%h want 1 40800000 3",
               res_valid, res_data, res_tag);
    end
    tick;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_c6 rv=%b want 0", res_valid);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [31:0] la [3];
    logic [31:0] ra [3];
    logic [31:0] ea [3];
    logic [MW-1:0] ma [3];
    logic et, er;
    int k;
    la = '{32'hC0600000, 32'h411B3333, 32'h43400000};
    ra = '{32'h40800000, 32'h3F000000, 32'h42800000};
    ea = '{32'hC1600000, 32'h409B3333, 32'h40400000};
    ma = '{MUL, MUL, DIV};
    for (int c = 1; c <= 8; c++) begin
      if (c <= 3)
        set_req(1, la[c-1], ra[c-1], ma[c-1], TW'(c));
      else
        set_req(0, 0, 0, 0, 0);
      @(negedge clk);
      et = (c >= 2) && (c <= 4);
      k = et ? c - 2 : 0;
      n_tests++;
      if ({fpu_trig, fpu_lhs, fpu_mode}
          !== {et, et ? la[k] : 32'h0, et ? ma[k] : 4'h0}) begin
        n_fail++;
        $display("FAIL b2b_trig c=%0d trig=%b lhs=%h want %b %h",
                 c, fpu_trig, fpu_lhs, et, la[k]);
      end
      er = (c >= 5) && (c <= 7);
      k = er ? c - 5 : 0;
      n_tests++;
      if ({res_valid, res_data, res_tag}
          !== {er, er ? ea[k] : 32'h0, er ? TW'(k + 1) : 4'h0}) begin
        n_fail++;
        $display("FAIL b2b_res c=%0d rv=%b data=%h tag=%h want %b %h %0d",
                 c, res_valid, res_data, res_tag, er, ea[k], k + 1);
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    int i, iss, base, n;
    logic [35:0] g, e;
    i = 0;
    iss = 0;
    res_ready = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (i < 10)
        set_req(1, 32'h30000000 | i, 32'h5500, 4'd1, TW'(i));
      else
        set_req(0, 0, 0, 0, 0);
      @(negedge clk);
      if (req_valid && req_ready) i++;
      if (fpu_trig) iss++;
      tick;
    end
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_ready rdy=%b want 0", req_ready);
    end
    n_tests++;
    if (i != 8) begin
      n_fail++;
      $display("FAIL bp_accepts got %0d want 8", i);
    end
    n_tests++;
    if (iss != 4) begin
      n_fail++;
      $display("FAIL bp_issues got %0d want 4", iss);
    end
    tick;
    base = got_q.size();
    res_ready = 1'b1;
    for (int c = 0; c < 100 && got_q.size() - base < 10; c++) begin
      if (i < 10)
        set_req(1, 32'h30000000 | i, 32'h5500, 4'd1, TW'(i));
      else
        set_req(0, 0, 0, 0, 0);
      @(negedge clk);
      if (req_valid && req_ready) i++;
      tick;
    end
    set_req(0, 0, 0, 0, 0);
    n = got_q.size() - base;
    n_tests++;
    if (n != 10) begin
      n_fail++;
      $display("FAIL bp_count got %0d want 10", n);
    end
    for (int k = 0; k < 10; k++) begin
      g = (k < n) ? got_q[base + k] : '1;
      e = {TW'(k), (32'h30000000 | k) ^ 32'h5500};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL bp_res k=%0d got %h want %h", k, g, e);
      end
    end
  endtask

  task automatic test_fifo_boundary;
    int i, base, n;
    logic [35:0] g, e;
    i = 0;
    res_ready = 1'b0;
    for (int c = 0; c < 40 && i < 7; c++) begin
      set_req(1, 32'h50000000 | i, 32'hAA, 4'd1, TW'(i));
      @(negedge clk);
      if (req_valid && req_ready) i++;
      tick;
    end
    set_req(0, 0, 0, 0, 0);
    repeat (6) tick;
    base = got_q.size();
    res_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fb_full_res rv=%b want 1", res_valid);
    end
    tick;
    res_ready = 1'b0;
    set_req(1, 32'h50000007, 32'hAA, 4'd1, 4'd7);
    @(negedge clk);
    n_tests++;
    if ({fpu_trig, req_ready, fpu_lhs}
        !== {1'b1, 1'b1, 32'h50000004}) begin
      n_fail++;
      $display("FAIL fb_push_pop trig=%b rdy=%b lhs=%h want 1 1 50000004",
               fpu_trig, req_ready, fpu_lhs);
    end
    tick;
    set_req(1, 32'h50000008, 32'hAA, 4'd1, 4'd8);
    @(negedge clk);
    n_tests++;
    if ({fpu_trig, req_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL fb_cnt_kept trig,rdy=%b want 01",
               {fpu_trig, req_ready});
    end
    tick;
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fb_full rdy=%b want 0", req_ready);
    end
    tick;
    res_ready = 1'b1;
    for (int c = 0; c < 60 && got_q.size() - base < 9; c++)
      tick;
    n = got_q.size() - base;
    n_tests++;
    if (n != 9) begin
      n_fail++;
      $display("FAIL fb_count got %0d want 9", n);
    end
    for (int k = 0; k < 9; k++) begin
      g = (k < n) ? got_q[base + k] : '1;
      e = {TW'(k), (32'h50000000 | k) ^ 32'hAA};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL fb_res k=%0d got %h want %h", k, g, e);
      end
    end
  endtask

  task automatic test_wrap;
    int i, base, n;
    logic [35:0] g, e;
    i = 0;
    res_ready = 1'b1;
    base = got_q.size();
    for (int c = 0; c < 100 && got_q.size() - base < 12; c++) begin
      if (i < 12)
        set_req(1, 32'h70000000 | i, 32'h0F0F0000, 4'd5, TW'(i));
      else
        set_req(0, 0, 0, 0, 0);
      @(negedge clk);
      if (req_valid && req_ready) i++;
      tick;
    end
    set_req(0, 0, 0, 0, 0);
    n = got_q.size() - base;
    n_tests++;
    if (n != 12) begin
      n_fail++;
      $display("FAIL wrap_count got %0d want 12", n);
    end
    for (int k = 0; k < 12; k++) begin
      g = (k < n) ? got_q[base + k] : '1;
      e = {TW'(k), (32'h70000000 | k) ^ 32'h0F0F0000};
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL wrap_res k=%0d got %h want %h", k, g, e);
      end
    end
  endtask

  task automatic test_error;
    inj = 1'b1;
    tick;
    inj = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({err, res_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_set err,rv=%b want 10", {err, res_valid});
    end
    repeat (3) tick;
    @(negedge clk);
    n_tests++;
    if ({err, res_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_sticky err,rv=%b want 10", {err, res_valid});
    end
    tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear err=%b want 0", err);
    end
    tick;
  endtask

  task automatic test_midop_reset;
    res_ready = 1'b1;
    set_req(1, 32'h11110000, 32'h1, 4'd1, 4'd1);
    tick;
    set_req(1, 32'h22220000, 32'h2, 4'd1, 4'd2);
    tick;
    set_req(0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (fpu_trig !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_issue2 trig=%b want 1", fpu_trig);
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({res_valid, fpu_trig} !== 2'b00) begin
      n_fail++;
      $display("FAIL mr_during rv,trig=%b want 00", {res_valid, fpu_trig});
    end
    tick;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({res_valid, req_ready, fpu_res_valid, err} !== 4'b0110) begin
      n_fail++;
      $display("FAIL mr_after rv,rdy,frv,err=%b want 0110",
               {res_valid, req_ready, fpu_res_valid, err});
    end
    tick;
    @(negedge clk);
    n_tests++;
    if ({res_valid, req_ready, err} !== 3'b011) begin
      n_fail++;
      $display("FAIL mr_err rv,rdy,err=%b want 011",
               {res_valid, req_ready, err});
    end
    tick;
    @(negedge clk);
    n_tests++;
    if ({res_valid, err} !== 2'b01) begin
      n_fail++;
      $display("FAIL mr_hold rv,err=%b want 01", {res_valid, err});
    end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_fifo_boundary;
    test_wrap;
    test_error;
    test_midop_reset;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
